// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU operations and
// immediate formats.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/control_unit.sv
// Combinational main decoder and ALU decoder for the supported RV32I subset.
module control_unit
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic       alu_src,
  output logic       mem_write,
  output logic       result_src,
  output logic       branch,
  output logic [2:0] alu_control
);

  logic [1:0] alu_op;

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    case (op)
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 1'b1;
      end
      OP_STORE: begin
        imm_src   = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  // funct7[5] selects sub only for register-register ops; addi reuses that bit as immediate.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// 32x32 architectural register file, x0 hardwired to zero, write-first read
// bypass so writeback and decode of the same register can share a cycle.
module register_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [32];
  logic            wr_active;

  assign wr_active = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_active) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 :
                  (wr_active && waddr == raddr1) ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 :
                  (wr_active && waddr == raddr2) ? wdata : mem[raddr2];

endmodule

// File: rtl/sign_extend.sv
// Builds the sign-extended I/S/B immediate from the instruction fields.
module sign_extend
  import riscv_pkg::*;
(
  input  logic [31:7]     instr,
  input  logic [1:0]      imm_src,
  output logic [XLEN-1:0] imm_ext
);

  always_comb begin
    case (imm_src)
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_ext = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension and
// the ID/EX pipeline register.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RD_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic        reg_write_d, alu_src_d, mem_write_d, result_src_d, branch_d;
  logic [1:0]  imm_src_d;
  logic [2:0]  alu_control_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d;

  control_unit u_control (
    .op          (InstrD[6:0]),
    .funct3      (InstrD[14:12]),
    .funct7_5    (InstrD[30]),
    .reg_write   (reg_write_d),
    .imm_src     (imm_src_d),
    .alu_src     (alu_src_d),
    .mem_write   (mem_write_d),
    .result_src  (result_src_d),
    .branch      (branch_d),
    .alu_control (alu_control_d)
  );

  register_file u_regs (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (RDW),
    .wdata  (ResultW),
    .raddr1 (InstrD[19:15]),
    .raddr2 (InstrD[24:20]),
    .rdata1 (rd1_d),
    .rdata2 (rd2_d)
  );

  sign_extend u_sext (
    .instr   (InstrD[31:7]),
    .imm_src (imm_src_d),
    .imm_ext (imm_ext_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      RD_E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write_d;
      ALUSrcE     <= alu_src_d;
      MemWriteE   <= mem_write_d;
      ResultSrcE  <= result_src_d;
      BranchE     <= branch_d;
      ALUControlE <= alu_control_d;
      RD1_E       <= rd1_d;
      RD2_E       <= rd2_d;
      Imm_Ext_E   <= imm_ext_d;
      RD_E        <= InstrD[11:7];
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: expected ID/EX contents are queued as each
// instruction is driven and compared after the capturing edge.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  // ctl = {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}
  typedef struct {
    logic [7:0]  ctl;
    logic        chk_imm;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  logic [31:0] model [32];
  logic [31:0] pc;
  int          errors = 0;
  int          checks = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] rs, input logic wbe,
                                              input logic [4:0] rdw, input logic [31:0] res);
    if (rs == 5'd0) return 32'd0;
    if (wbe && rdw == rs) return res;
    return model[rs];
  endfunction

  task automatic compare_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check32({t, "_ctl"}, {24'd0, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE},
            {24'd0, e.ctl});
    if (e.chk_imm) check32({t, "_imm"}, Imm_Ext_E, e.imm);
    check32({t, "_rd1"}, RD1_E, e.rd1);
    check32({t, "_rd2"}, RD2_E, e.rd2);
    check32({t, "_rd"}, {27'd0, RD_E}, {27'd0, e.rd});
    check32({t, "_pc"}, PCE, e.pc);
    check32({t, "_pc4"}, PCPlus4E, e.pc4);
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [7:0] ctl,
                      input logic chk_imm, input logic [31:0] imm, input logic wbe,
                      input logic [4:0] rdw, input logic [31:0] res);
    exp_t e;
    rst       = 1'b0;
    InstrD    = instr;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    RegWriteW = wbe;
    RDW       = rdw;
    ResultW   = res;
    e.ctl     = ctl;
    e.chk_imm = chk_imm;
    e.imm     = imm;
    e.rd1     = model_read(instr[19:15], wbe, rdw, res);
    e.rd2     = model_read(instr[24:20], wbe, rdw, res);
    e.rd      = instr[11:7];
    e.pc      = pc;
    e.pc4     = pc + 32'd4;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (wbe && rdw != 5'd0) model[rdw] = res;
    @(posedge clk);
    #1;
    compare_out();
    pc = pc + 32'd4;
  endtask

  task automatic reset_step(input string tag, input logic [31:0] instr, input logic wbe,
                            input logic [4:0] rdw, input logic [31:0] res);
    exp_t e;
    rst       = 1'b1;
    InstrD    = instr;
    PCD       = 32'h0000_1000;
    PCPlus4D  = 32'h0000_1004;
    RegWriteW = wbe;
    RDW       = rdw;
    ResultW   = res;
    e.ctl = '0; e.chk_imm = 1'b1; e.imm = '0; e.rd1 = '0; e.rd2 = '0;
    e.rd  = '0; e.pc = '0; e.pc4 = '0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(posedge clk);
    #1;
    compare_out();
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  initial begin
    pc = 32'd0;
    reset_step("rst1", 32'h00402283, 1'b1, 5'd7, 32'hAAAA_5555);
    reset_step("rst2", 32'h00402283, 1'b1, 5'd7, 32'hAAAA_5555);
    step("rd_after_rst", r_add(5'd1, 5'd7, 5'd31), 8'h80, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);

    pc = 32'd0;
    step("lw", 32'h00402283, 8'hD0, 1'b1, 32'd4, 1'b0, 5'd0, 32'd0);
    step("wb_x5", 32'h00402283, 8'hD0, 1'b1, 32'd4, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step("add_read", 32'h00528333, 8'h80, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("bypass", 32'h00528333, 8'h80, 1'b0, 32'd0, 1'b1, 5'd5, 32'hCAFE_F00D);
    step("after_bypass", 32'h00528333, 8'h80, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("x0_write", 32'h00000333, 8'h80, 1'b0, 32'd0, 1'b1, 5'd0, 32'h0000_1234);
    step("x0_read", 32'h00000333, 8'h80, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("sub_wb_x6", 32'h40628333, 8'h81, 1'b0, 32'd0, 1'b1, 5'd6, 32'h0000_0011);
    step("sw", 32'hFE532E23, 8'h60, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'd0);
    step("beq", 32'hFE000EE3, 8'h09, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'd0);
    step("and", 32'h0062F333, 8'h82, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("or", 32'h0062E333, 8'h83, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("slt", 32'h0062A333, 8'h85, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("addi", 32'hFFF28313, 8'hC0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    step("unknown", 32'h0000007F, 8'h00, 1'b1, 32'd0, 1'b0, 5'd0, 32'd0);
    step("lui_unsup", 32'h12345037, 8'h00, 1'b1, 32'h0000_0123, 1'b0, 5'd0, 32'd0);

    for (int r = 1; r < 32; r++)
      step("fill", 32'h0000007F, 8'h00, 1'b1, 32'd0, 1'b1, 5'(r), $urandom);
    for (int r = 1; r < 32; r++)
      step("readback", r_add(5'd1, 5'(r), 5'(r * 7)), 8'h80, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);

    step("pre_rst", 32'h00528333, 8'h80, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    reset_step("mid_rst", 32'h00528333, 1'b1, 5'd5, 32'hFFFF_0000);
    step("rd_after_mid_rst", 32'h00528333, 8'h80, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Instruction-decode stage of the five-stage RV32I pipeline, placed between the fetch stage (IF/ID register) and the execute stage. It decodes `InstrD` into control signals and owns the architectural register file, which the writeback stage writes through `RegWriteW/RDW/ResultW`. It also sign-extends the immediate and registers everything into the ID/EX pipeline register, so execute sees the decoded instruction one cycle later.

## Interface
Parameters: none (widths fixed: XLEN=32, 32 registers).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `InstrD` in 32: instruction from IF/ID.
- `PCD` in 32: PC of `InstrD`.
- `PCPlus4D` in 32: PC+4 of `InstrD`.
- `RegWriteW` in 1: writeback register-write enable.
- `RDW` in 5: writeback destination register.
- `ResultW` in 32: writeback data.
- `RegWriteE` out 1: register write enable.
- `ALUSrcE` out 1: 1 = ALU operand B is the immediate.
- `MemWriteE` out 1: store.
- `ResultSrcE` out 1: 1 = result comes from data memory.
- `BranchE` out 1: conditional branch.
- `ALUControlE` out 3: ALU operation.
- `RD1_E` out 32: rs1 value.
- `RD2_E` out 32: rs2 value.
- `Imm_Ext_E` out 32: sign-extended immediate.
- `RD_E` out 5: destination register (`InstrD[11:7]`).
- `PCE` out 32: registered `PCD`.
- `PCPlus4E` out 32: registered `PCPlus4D`.

## Operation
Main decoder, on opcode `InstrD[6:0]`. Signal order is RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp.
- lw `0000011`: 1, I, 1, 0, 1, 0, 00
- sw `0100011`: 0, S, 1, 1, 0, 0, 00
- R-type `0110011`: 1, –, 0, 0, 0, 0, 10
- I-ALU `0010011`: 1, I, 1, 0, 0, 0, 10
- beq `1100011`: 0, B, 0, 0, 0, 1, 01
- Any other opcode: all controls 0, ImmSrc=I.

ALU decoder:
- ALUOp=00 → 000 (add).
- ALUOp=01 → 001 (sub).
- ALUOp=10, selected by funct3:
  - funct3=000: 001 (sub) only if R-type and funct7[5]=1; otherwise 000.
  - 010 → 101 (slt)
  - 110 → 011 (or)
  - 111 → 010 (and)
  - other funct3 → 000.

Immediate extension (always sign-extended from `InstrD[31]`):
- I: `{20×I[31], I[31:20]}`
- S: `{20×I[31], I[31:25], I[11:7]}`
- B: `{19×I[31], I[31], I[7], I[30:25], I[11:8], 0}`

Register file:
- 32×32 storage.
- rs1=`InstrD[19:15]`, rs2=`InstrD[24:20]`; both reads are combinational.
- x0 always reads 0 and ignores writes.
- Write occurs at the rising edge when `RegWriteW=1` and `RDW≠0`.
- Write-first bypass: if the same cycle writes a register that is also being read (nonzero), the read returns `ResultW`.
- Synchronous reset clears all registers to 0.

## Timing
- Latency: 1 cycle. Every `*E` output reflects the `*D` inputs present at the previous rising edge.
- No stall or flush inputs; the pipeline register loads on every non-reset edge.
- Reset (`rst=1` at an edge): every output becomes 0 and all registers clear. This takes priority over a simultaneous writeback.
- Reset mid-operation discards the instruction in flight.
- Before the first reset, outputs are undefined.
- Simultaneous writeback and read of the same register (e.g. `RDW=rs1=5`, `RegWriteW=1`): `RD1_E` captures `ResultW` at that edge. The file is updated at the same edge.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants;
  - ALUOp and ALUControl encodings;
  - ImmSrc encodings;
  - XLEN=32.
- Sub-modules:
  - `control_unit`: main decoder plus ALU decoder, combinational.
  - `register_file`.
  - `sign_extend`.
- The ID/EX register lives in `decode_cycle` itself.

## Test plan
- Reset: hold `rst=1` for 2 edges → all outputs 0; afterwards, reading any register returns 0.
- lw: `InstrD=0x00402283`, `PCD=0`, `PCPlus4D=4`, `RegWriteW=0`. After one edge:
  - RegWriteE=1, ALUSrcE=1, MemWriteE=0, ResultSrcE=1, BranchE=0, ALUControlE=000
  - Imm_Ext_E=4, RD_E=5, RD1_E=0, RD2_E=0, PCE=0, PCPlus4E=4
- Writeback then read:
  - Cycle 1: `RegWriteW=1`, `RDW=5`, `ResultW=0xDEADBEEF`.
  - Cycle 2: `InstrD=0x00528333` (add x6,x5,x5).
  - Expect RD1_E=RD2_E=0xDEADBEEF and ALUControlE=000.
  - A simultaneous write and read of x5 gives the same result through the bypass.
- x0 protection: write `RDW=0`, `ResultW=0x1234` → a later read of x0 returns 0.
- Immediate and branch forms:
  - sw `0xFE532E23` → Imm_Ext_E=0xFFFFFFFC, MemWriteE=1, RegWriteE=0.
  - beq `0xFE000EE3` → BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFFC.
- ALU decode:
  - sub `0x40628333` → 001
  - and `0x0062F333` → 010
  - or `0x0062E333` → 011
  - slt `0x0062A333` → 101
  - addi `0xFFF28313` → 000 with Imm=0xFFFFFFFF
  - unknown opcode `0x0000007F` → all controls 0
